// File: rtl/cb_addr_sched.sv
// Covariance-buffer address scheduler: sweeps groups 0..landmark_num,
// driving a thermometer bank enable and a per-group BANK0 base address.
module cb_addr_sched #(
  parameter int L             = 4,
  parameter int CB_AW         = 19,
  parameter int ROW_LEN       = 10,
  parameter int STATE_CNT_MAX = 5
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ROW_LEN-1:0] landmark_num,
  input  logic [CB_AW-1:0]   base_addr,
  input  logic [CB_AW-1:0]   row_stride,
  output logic [L-1:0]       CB_en,
  output logic               group_cnt_0,
  output logic [CB_AW-1:0]   din,
  output logic               addr_vld,
  output logic               busy,
  output logic               done
);

  localparam int SW = (STATE_CNT_MAX > 0) ?
                      $clog2(STATE_CNT_MAX + 1) : 1;
  localparam int DW = (L > 2) ? $clog2(L - 1) : 1;

  localparam logic [SW-1:0] SLAST = SW'(STATE_CNT_MAX);
  localparam logic [DW-1:0] DLAST = DW'((L > 1) ? L - 2 : 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } st_t;

  st_t                state, state_n;
  logic [SW-1:0]      sc, sc_n;
  logic [ROW_LEN-1:0] gc, gc_n;
  logic [DW-1:0]      dc, dc_n;
  logic [ROW_LEN-1:0] lm, lm_n;
  logic [CB_AW-1:0]   stride, stride_n;
  logic [CB_AW-1:0]   din_n;
  logic [L-1:0]       en_n;
  logic               vld_n;
  logic               g0_n;
  logic               busy_n;
  logic               done_n;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      sc          <= '0;
      gc          <= '0;
      dc          <= '0;
      lm          <= '0;
      stride      <= '0;
      din         <= '0;
      CB_en       <= '0;
      addr_vld    <= 1'b0;
      group_cnt_0 <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      sc          <= sc_n;
      gc          <= gc_n;
      dc          <= dc_n;
      lm          <= lm_n;
      stride      <= stride_n;
      din         <= din_n;
      CB_en       <= en_n;
      addr_vld    <= vld_n;
      group_cnt_0 <= g0_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    sc_n     = sc;
    gc_n     = gc;
    dc_n     = dc;
    lm_n     = lm;
    stride_n = stride;
    din_n    = din;
    done_n   = 1'b0;
    en_n     = '0;
    vld_n    = 1'b0;
    g0_n     = 1'b0;
    busy_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = RUN;
          sc_n     = '0;
          gc_n     = '0;
          dc_n     = '0;
          lm_n     = landmark_num;
          stride_n = row_stride;
          din_n    = base_addr;
        end
      end
      RUN: begin
        if (abort) begin
          state_n  = IDLE;
          sc_n     = '0;
          gc_n     = '0;
          dc_n     = '0;
          lm_n     = '0;
          stride_n = '0;
          din_n    = '0;
        end else if (sc == SLAST) begin
          if (gc == lm) begin
            // last group: freeze counters, let the wavefront drain
            dc_n = '0;
            if (L > 1) begin
              state_n = DRAIN;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            sc_n  = '0;
            gc_n  = gc + ROW_LEN'(1);
            din_n = din + stride;
          end
        end else begin
          sc_n = sc + SW'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          state_n  = IDLE;
          sc_n     = '0;
          gc_n     = '0;
          dc_n     = '0;
          lm_n     = '0;
          stride_n = '0;
          din_n    = '0;
        end else if (dc == DLAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          dc_n = dc + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // outputs are registered from the next-state view
    busy_n = (state_n != IDLE);
    if (state_n == RUN) begin
      for (int i = 0; i < L; i++) begin
        en_n[i] = (int'(sc_n) >= i);
      end
      vld_n = (int'(sc_n) <= L - 1);
      g0_n  = gc_n[0];
    end
  end

endmodule

// File: tb/tb_cb_addr_sched.sv
// Self-checking bench for cb_addr_sched against a per-cycle
// trace model built from the sweep rules.
module tb_cb_addr_sched;

  localparam int L    = 4;
  localparam int AW   = 19;
  localparam int RL   = 10;
  localparam int SMAX = 5;

  logic          clk;
  logic          sys_rst;
  logic          start;
  logic          abort;
  logic [RL-1:0] landmark_num;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] row_stride;
  logic [L-1:0]  CB_en;
  logic          group_cnt_0;
  logic [AW-1:0] din;
  logic          addr_vld;
  logic          busy;
  logic          done;

  int checks;
  int failures;

  cb_addr_sched #(
    .L(L),
    .CB_AW(AW),
    .ROW_LEN(RL),
    .STATE_CNT_MAX(SMAX)
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .start(start),
    .abort(abort),
    .landmark_num(landmark_num),
    .base_addr(base_addr),
    .row_stride(row_stride),
    .CB_en(CB_en),
    .group_cnt_0(group_cnt_0),
    .din(din),
    .addr_vld(addr_vld),
    .busy(busy),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L-1:0] thermo(input int s);
    int k;
    k = (s + 1 > L) ? L : s + 1;
    return L'((1 << k) - 1);
  endfunction

  function automatic logic [AW-1:0] addr_of(input longint b,
                                            input longint st,
                                            input int g);
    longint a;
    a = b + longint'(g) * st;
    return AW'(a % (longint'(1) << AW));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, CB_en, 0);
    check({tag, "_vld"}, addr_vld, 0);
    check({tag, "_g0"}, group_cnt_0, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic scramble();
    start        = 1'($urandom_range(0, 1));
    landmark_num = RL'($urandom);
    base_addr    = AW'($urandom);
    row_stride   = AW'($urandom);
  endtask

  // full sweep; must be called at posedge+1 with the DUT idle
  task automatic run_sweep(input int n,
                           input logic [AW-1:0] b,
                           input logic [AW-1:0] st,
                           input bit noise,
                           input bit abort_too);
    start        = 1'b1;
    abort        = abort_too;
    landmark_num = RL'(n);
    base_addr    = b;
    row_stride   = st;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int g = 0; g <= n; g++) begin
      for (int s = 0; s <= SMAX; s++) begin
        check("run_busy", busy, 1);
        check("run_en", CB_en, thermo(s));
        check("run_din", din, addr_of(b, st, g));
        check("run_g0", group_cnt_0, g & 1);
        check("run_vld", addr_vld, (s <= L - 1) ? 1 : 0);
        check("run_done", done, 0);
        if (noise) scramble();
        step();
      end
    end
    for (int d = 0; d < L - 1; d++) begin
      check("drn_busy", busy, 1);
      check("drn_en", CB_en, 0);
      check("drn_vld", addr_vld, 0);
      check("drn_g0", group_cnt_0, 0);
      check("drn_done", done, 0);
      if (noise) scramble();
      step();
    end
    start = 1'b0;
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_en", CB_en, 0);
    step();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
  endtask

  task automatic abort_run(input logic [AW-1:0] b,
                           input logic [AW-1:0] st);
    start        = 1'b1;
    landmark_num = RL'(3);
    base_addr    = b;
    row_stride   = st;
    step();
    start = 1'b0;
    for (int k = 0; k < SMAX + 3; k++) begin
      check("ab_din", din, addr_of(b, st, k / (SMAX + 1)));
      check("ab_busy", busy, 1);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("ab_after");
    check("ab_din0", din, 0);
    for (int k = 0; k < 12; k++) begin
      check("ab_nodone", done, 0);
      check("ab_idle", busy, 0);
      step();
    end
  endtask

  task automatic reset_in_drain();
    start        = 1'b1;
    landmark_num = '0;
    base_addr    = 19'h00123;
    row_stride   = 19'h00010;
    step();
    start = 1'b0;
    for (int k = 0; k < SMAX + 2; k++) step();
    check("rd_busy_pre", busy, 1);
    sys_rst = 1'b1;
    #1;
    check_idle("rd_async");
    check("rd_din0", din, 0);
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("rd_nodone", done, 0);
      check("rd_idle", busy, 0);
      step();
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    sys_rst      = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    landmark_num = '0;
    base_addr    = '0;
    row_stride   = '0;
    #12;
    check_idle("rst");
    check("rst_din", din, 0);
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    step();
    check_idle("rel");

    run_sweep(0, 19'h00100, 19'h00040, 1'b0, 1'b0);
    run_sweep(2, 19'h00100, 19'h00040, 1'b0, 1'b0);
    run_sweep(1, 19'h7FFC0, 19'h00080, 1'b0, 1'b0);

    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("idle_abort");

    run_sweep(1, AW'($urandom), AW'($urandom), 1'b0, 1'b1);
    abort_run(AW'($urandom), AW'($urandom));
    run_sweep(3, AW'($urandom), AW'($urandom), 1'b0, 1'b0);
    reset_in_drain();
    run_sweep(0, AW'($urandom), AW'($urandom), 1'b0, 1'b0);
    run_sweep(2, AW'($urandom), AW'($urandom), 1'b1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      run_sweep($urandom_range(0, 5), AW'($urandom),
                AW'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    run_sweep((1 << RL) - 1, AW'($urandom), AW'($urandom),
              1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cb_addr_sched.md
CB_ADDR_SCHED -- requirements
Module: cb_addr_sched

Interface
REQ-001 Parameter L, default 4, number of covariance-buffer banks driven by the address shifter.
REQ-002 Parameter CB_AW, default 19, covariance-buffer address width.
REQ-003 Parameter ROW_LEN, default 10, width of landmark/group counters.
REQ-004 Parameter STATE_CNT_MAX, default 5, last state_cnt value of one group (group length STATE_CNT_MAX+1 cycles); SHALL be >= L-1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 sys_rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-008 abort  in  1  synchronous cancel of a running sweep.
REQ-009 landmark_num  in  ROW_LEN  last group index (sweep covers groups 0..landmark_num).
REQ-010 base_addr  in  CB_AW  BANK0 row base for group 0; captured at start.
REQ-011 row_stride  in  CB_AW  BANK0 address increment per group; captured at start.
REQ-012 CB_en  out  L  per-bank enable to the shifter.
REQ-013 group_cnt_0  out  1  LSB of current group index (shifter mode select).
REQ-014 din  out  CB_AW  BANK0 base address for the current group.
REQ-015 addr_vld  out  1  high while shifter output carries a valid address wavefront.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 done  out  1  one-cycle pulse at sweep completion.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; start in IDLE -> RUN next cycle; start outside IDLE ignored.
REQ-019 On accepted start: latch landmark_num, base_addr, row_stride; group_cnt<=0, state_cnt<=0, din<=base_addr.
REQ-020 In RUN state_cnt increments 0..STATE_CNT_MAX and wraps to 0; on wrap group_cnt increments and din<=din+row_stride (modulo 2^CB_AW, carry discarded).
REQ-021 group_cnt_0 SHALL equal group_cnt[0] in RUN; 0 in IDLE and DRAIN.
REQ-022 In RUN, CB_en bit i = 1 iff i <= state_cnt (thermometer, saturates all-ones for state_cnt >= L-1); CB_en=0 in IDLE and DRAIN.
REQ-023 addr_vld = 1 in RUN when state_cnt <= L-1, else 0.
REQ-024 When state_cnt==STATE_CNT_MAX and group_cnt==latched landmark_num: RUN -> DRAIN, counters not advanced further.
REQ-025 DRAIN lasts exactly L-1 cycles (drain counter), then done=1 for one cycle coincident with return to IDLE.
REQ-026 landmark_num==0: exactly one group (STATE_CNT_MAX+1 RUN cycles) then DRAIN.
REQ-027 landmark_num = 2^ROW_LEN-1: group_cnt reaches max without overflow; sweep terminates via REQ-024.
REQ-028 abort in RUN or DRAIN: next state IDLE, all outputs to reset values, no done pulse; abort in IDLE has no effect.
REQ-029 abort and start same cycle in IDLE: start accepted; abort ignored.
REQ-030 Input changes during busy SHALL NOT affect the running sweep (latched values only).
REQ-031 Total sweep latency start -> done = 1 + (landmark_num+1)*(STATE_CNT_MAX+1) + (L-1) cycles.
REQ-032 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-033 sys_rst asserted (any time, incl. mid-sweep): immediately FSM=IDLE, CB_en=0, group_cnt_0=0, din=0, addr_vld=0, busy=0, done=0, all counters and latched inputs 0.
REQ-034 After sys_rst deassertion, first start is accepted normally.

Verification
REQ-035 L=4, STATE_CNT_MAX=5, start with landmark_num=0, base_addr=0x100, row_stride=0x40 -> RUN 6 cycles, din=0x100, CB_en 0001,0011,0111,1111,1111,1111, DRAIN 3 cycles, done at cycle 10 after start.
REQ-036 landmark_num=2, base_addr=0x100, row_stride=0x40 -> din 0x100/0x140/0x180, group_cnt_0 0/1/0, done after 1+18+3=22 cycles.
REQ-037 base_addr=0x7FFC0, row_stride=0x80, landmark_num=1 -> second group din=0x00040 (wrap, CB_AW=19).
REQ-038 abort during group 1 of 3 -> next cycle busy=0, CB_en=0, din=0, no done; subsequent start runs a full sweep.
REQ-039 sys_rst pulse mid-DRAIN -> outputs zero without waiting for clock edge; no done; start after release accepted.
REQ-040 start re-asserted and inputs changed while busy -> ignored; sweep finishes with originally latched values and a single done.
